// File: rtl/superscalar_pkg.sv
// Shared decode constants and enums for the dual-issue MIPS front end.
// Used by issue_decode and issue_pair_scheduler.
package superscalar_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_MEM,
    CLS_CTRL
  } cls_e;

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_e;

endpackage

// File: rtl/issue_pair_scheduler_if.sv
// Fetch-pair in / issue-slot out bundle for issue_pair_scheduler.
// Counter signals exist only when ISSUE_STATS_EN is defined.
interface issue_pair_scheduler_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] instA;
  logic [XLEN-1:0] instB;
  logic [XLEN-1:0] pcA;
  logic            stall;
  logic            flush;
  logic            slot0_valid;
  logic            slot1_valid;
  logic [XLEN-1:0] slot0_inst;
  logic [XLEN-1:0] slot1_inst;
  logic [XLEN-1:0] slot0_pc;
  logic [XLEN-1:0] slot1_pc;
  logic            split;
`ifdef ISSUE_STATS_EN
  logic [31:0]     dual_cnt;
  logic [31:0]     single_cnt;
`endif

  modport master (
    output in_valid, instA, instB, pcA,
    output stall, flush,
    input  in_ready,
    input  slot0_valid, slot1_valid,
    input  slot0_inst, slot1_inst,
    input  slot0_pc, slot1_pc,
    input  split
`ifdef ISSUE_STATS_EN
    , input dual_cnt, single_cnt
`endif
  );

  modport slave (
    input  in_valid, instA, instB, pcA,
    input  stall, flush,
    output in_ready,
    output slot0_valid, slot1_valid,
    output slot0_inst, slot1_inst,
    output slot0_pc, slot1_pc,
    output split
`ifdef ISSUE_STATS_EN
    , output dual_cnt, single_cnt
`endif
  );

endinterface

// File: rtl/issue_decode.sv
// Per-instruction class and register-use decode for pair hazard checks.
// Purely combinational; instantiated once per pair slot.
module issue_decode
  import superscalar_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_inst,
  output cls_e            o_cls,
  output logic [4:0]      o_dst,
  output logic            o_dst_v,
  output logic [4:0]      o_src1,
  output logic            o_src1_v,
  output logic [4:0]      o_src2,
  output logic            o_src2_v
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic       w_has;

  assign w_op = i_inst[31:26];
  assign w_rs = i_inst[25:21];
  assign w_rt = i_inst[20:16];
  assign w_rd = i_inst[15:11];
  assign w_fn = i_inst[5:0];

  always_comb begin
    o_cls    = CLS_ALU;
    o_dst    = 5'd0;
    w_has    = 1'b0;
    o_src1   = w_rs;
    o_src2   = w_rt;
    o_src1_v = 1'b0;
    o_src2_v = 1'b0;
    unique case (1'b1)
      (w_op == OP_RTYPE) && (w_fn == FN_JR): begin
        o_cls    = CLS_CTRL;
        o_src1_v = 1'b1;
      end
      (w_op == OP_RTYPE) && (w_fn != FN_JR): begin
        o_dst    = w_rd;
        w_has    = 1'b1;
        o_src1_v = 1'b1;
        o_src2_v = 1'b1;
      end
      w_op == OP_LW: begin
        o_cls    = CLS_MEM;
        o_dst    = w_rt;
        w_has    = 1'b1;
        o_src1_v = 1'b1;
      end
      w_op == OP_SW: begin
        o_cls    = CLS_MEM;
        o_src1_v = 1'b1;
        o_src2_v = 1'b1;
      end
      (w_op == OP_ADDI) || (w_op == OP_ANDI) ||
      (w_op == OP_ORI)  || (w_op == OP_XORI): begin
        o_dst    = w_rt;
        w_has    = 1'b1;
        o_src1_v = 1'b1;
      end
      (w_op == OP_BEQ) || (w_op == OP_BNE): begin
        o_cls    = CLS_CTRL;
        o_src1_v = 1'b1;
        o_src2_v = 1'b1;
      end
      w_op == OP_J: begin
        o_cls = CLS_CTRL;
      end
      w_op == OP_JAL: begin
        o_cls = CLS_CTRL;
        o_dst = 5'd31;
        w_has = 1'b1;
      end
      default: ;
    endcase
    // $0 is never a real write target
    o_dst_v = w_has && (o_dst != 5'd0);
  end

endmodule

// File: rtl/issue_pair_scheduler.sv
// Dual-issue pair scheduler: pairs or splits an aligned fetch pair.
// Optional issue counters under `ISSUE_STATS_EN.
module issue_pair_scheduler
  import superscalar_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic                  clk,
  input logic                  rst,
  issue_pair_scheduler_if.slave io_bus
);

  cls_e       w_a_cls, w_b_cls;
  logic [4:0] w_a_dst, w_b_dst;
  logic       w_a_dv, w_b_dv;
  logic [4:0] w_a_s1, w_a_s2, w_b_s1, w_b_s2;
  logic       w_a_s1v, w_a_s2v, w_b_s1v, w_b_s2v;

  issue_decode #(.XLEN(XLEN)) u_dec_a (
    .i_inst  (io_bus.instA),
    .o_cls   (w_a_cls),
    .o_dst   (w_a_dst),
    .o_dst_v (w_a_dv),
    .o_src1  (w_a_s1),
    .o_src1_v(w_a_s1v),
    .o_src2  (w_a_s2),
    .o_src2_v(w_a_s2v)
  );

  issue_decode #(.XLEN(XLEN)) u_dec_b (
    .i_inst  (io_bus.instB),
    .o_cls   (w_b_cls),
    .o_dst   (w_b_dst),
    .o_dst_v (w_b_dv),
    .o_src1  (w_b_s1),
    .o_src1_v(w_b_s1v),
    .o_src2  (w_b_s2),
    .o_src2_v(w_b_s2v)
  );

  state_e          r_state;
  logic            r_s0v, r_s1v, r_split;
  logic [XLEN-1:0] r_s0i, r_s1i, r_s0pc, r_s1pc;
  logic [XLEN-1:0] r_hold_i, r_hold_pc;

  logic            w_raw, w_waw, w_pair_ok, w_take;
  logic [XLEN-1:0] w_pcb;

  assign w_raw = w_a_dv &&
    ((w_b_s1v && (w_b_s1 == w_a_dst)) ||
     (w_b_s2v && (w_b_s2 == w_a_dst)));
  assign w_waw = w_a_dv && w_b_dv &&
    (w_a_dst == w_b_dst);
  assign w_pair_ok =
    !((w_a_cls == CLS_MEM) && (w_b_cls == CLS_MEM)) &&
    (w_a_cls != CLS_CTRL) &&
    (w_b_cls != CLS_CTRL) &&
    !w_raw && !w_waw;

  assign w_pcb = io_bus.pcA + XLEN'(4);

  assign io_bus.in_ready = !rst && (r_state == S_IDLE) &&
    !io_bus.stall && !io_bus.flush;
  assign w_take = io_bus.in_valid && io_bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_s0v     <= 1'b0;
      r_s1v     <= 1'b0;
      r_s0i     <= '0;
      r_s1i     <= '0;
      r_s0pc    <= '0;
      r_s1pc    <= '0;
      r_split   <= 1'b0;
      r_hold_i  <= '0;
      r_hold_pc <= '0;
    end else if (io_bus.flush) begin
      r_state <= S_IDLE;
      r_s0v   <= 1'b0;
      r_s1v   <= 1'b0;
    end else if (!io_bus.stall) begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_s0v   <= 1'b1;
            r_s0i   <= io_bus.instA;
            r_s0pc  <= io_bus.pcA;
            r_split <= !w_pair_ok;
            if (w_pair_ok) begin
              r_s1v  <= 1'b1;
              r_s1i  <= io_bus.instB;
              r_s1pc <= w_pcb;
            end else begin
              r_s1v     <= 1'b0;
              r_hold_i  <= io_bus.instB;
              r_hold_pc <= w_pcb;
              r_state   <= S_HOLD;
            end
          end else begin
            r_s0v <= 1'b0;
            r_s1v <= 1'b0;
          end
        end
        S_HOLD: begin
          r_s0v   <= 1'b1;
          r_s0i   <= r_hold_i;
          r_s0pc  <= r_hold_pc;
          r_s1v   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.slot0_valid = r_s0v;
  assign io_bus.slot1_valid = r_s1v;
  assign io_bus.slot0_inst  = r_s0i;
  assign io_bus.slot1_inst  = r_s1i;
  assign io_bus.slot0_pc    = r_s0pc;
  assign io_bus.slot1_pc    = r_s1pc;
  assign io_bus.split       = r_split;

`ifdef ISSUE_STATS_EN
  logic [31:0] r_dual, r_single;

  // counts survive flush; only reset clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dual   <= '0;
      r_single <= '0;
    end else if (!io_bus.flush && !io_bus.stall) begin
      if (r_state == S_HOLD)
        r_single <= r_single + 32'd1;
      else if (w_take && w_pair_ok)
        r_dual <= r_dual + 32'd1;
      else if (w_take)
        r_single <= r_single + 32'd1;
    end
  end

  assign io_bus.dual_cnt   = r_dual;
  assign io_bus.single_cnt = r_single;
`endif

endmodule

// File: tb/tb_issue_pair_scheduler.sv
// Random + directed bench for issue_pair_scheduler with a queue model.
// Counter checks enabled when ISSUE_STATS_EN is defined.
module tb_issue_pair_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  issue_pair_scheduler_if #(.XLEN(32)) bus();

  issue_pair_scheduler #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Spec-level decode: write target (0 = none) and read-set bitmask
  function automatic void tb_dec(input logic [31:0] w,
    output bit mem, output bit ctl, output int wr,
    output logic [31:0] rmask);
    int op, rs, rt, rd, fn;
    bit imm_w;
    op = int'(w[31:26]); rs = int'(w[25:21]);
    rt = int'(w[20:16]); rd = int'(w[15:11]);
    fn = int'(w[5:0]);
    imm_w = (op == 8 || op == 12 || op == 13 ||
             op == 14 || op == 35);
    mem = (op == 35 || op == 43);
    ctl = (op >= 2 && op <= 5) || (op == 0 && fn == 8);
    wr = 0;
    rmask = '0;
    if (op == 0 && fn != 8) wr = rd;
    else if (imm_w) wr = rt;
    else if (op == 3) wr = 31;
    if (op == 0) begin
      rmask[rs] = 1'b1;
      if (fn != 8) rmask[rt] = 1'b1;
    end else if (imm_w) begin
      rmask[rs] = 1'b1;
    end else if (op == 43 || op == 4 || op == 5) begin
      rmask[rs] = 1'b1;
      rmask[rt] = 1'b1;
    end
  endfunction

  function automatic bit pairable(logic [31:0] a, logic [31:0] b);
    bit ma, ca, mb, cb;
    int wa, wb;
    logic [31:0] ra, rb;
    tb_dec(a, ma, ca, wa, ra);
    tb_dec(b, mb, cb, wb, rb);
    if (ma && mb) return 1'b0;
    if (ca || cb) return 1'b0;
    if (wa != 0 && rb[wa]) return 1'b0;
    if (wa != 0 && wa == wb) return 1'b0;
    return 1'b1;
  endfunction

  typedef struct {
    logic [31:0] i0, p0, i1, p1;
    bit two;
  } grp_t;

  grp_t q[$];
  bit          e_s0v = 0, e_s1v = 0, e_split = 0;
  logic [31:0] e_s0i = 0, e_s1i = 0, e_s0p = 0, e_s1p = 0;
  logic [31:0] e_dual = 0, e_single = 0;
  bit          acc_last = 0;

  function automatic bit exp_ready();
    return !rst && !bus.stall && !bus.flush && (q.size() == 0);
  endfunction

  // Model: accepted pairs become issue groups; one group per free cycle
  always @(posedge clk) begin
    bit rdy;
    grp_t g;
    rdy = exp_ready();
    acc_last = 1'b0;
    if (rst) begin
      q.delete();
      e_s0v = 0; e_s1v = 0; e_split = 0;
      e_s0i = 0; e_s1i = 0; e_s0p = 0; e_s1p = 0;
      e_dual = 0; e_single = 0;
    end else if (bus.flush) begin
      q.delete();
      e_s0v = 0; e_s1v = 0;
    end else if (!bus.stall) begin
      if (bus.in_valid && rdy) begin
        acc_last = 1'b1;
        if (pairable(bus.instA, bus.instB)) begin
          q.push_back('{bus.instA, bus.pcA, bus.instB,
                        bus.pcA + 32'd4, 1'b1});
          e_split = 0;
        end else begin
          q.push_back('{bus.instA, bus.pcA, 0, 0, 1'b0});
          q.push_back('{bus.instB, bus.pcA + 32'd4, 0, 0, 1'b0});
          e_split = 1;
        end
      end
      if (q.size() > 0) begin
        g = q.pop_front();
        e_s0v = 1; e_s0i = g.i0; e_s0p = g.p0;
        e_s1v = g.two;
        if (g.two) begin
          e_s1i = g.i1; e_s1p = g.p1;
          e_dual = e_dual + 1;
        end else begin
          e_single = e_single + 1;
        end
      end else begin
        e_s0v = 0; e_s1v = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ready()));
      chk("slot0_valid", 32'(bus.slot0_valid), 32'(e_s0v));
      chk("slot1_valid", 32'(bus.slot1_valid), 32'(e_s1v));
      chk("split", 32'(bus.split), 32'(e_split));
      if (e_s0v) begin
        chk("slot0_inst", bus.slot0_inst, e_s0i);
        chk("slot0_pc", bus.slot0_pc, e_s0p);
      end
      if (e_s1v) begin
        chk("slot1_inst", bus.slot1_inst, e_s1i);
        chk("slot1_pc", bus.slot1_pc, e_s1p);
      end
`ifdef ISSUE_STATS_EN
      chk("dual_cnt", bus.dual_cnt, e_dual);
      chk("single_cnt", bus.single_cnt, e_single);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(logic [31:0] a, logic [31:0] b, logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.instA = a;
    bus.instB = b;
    bus.pcA = pc;
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [4:0] rs, rt, rd;
    logic [5:0] fn;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 12))
      0, 1: begin
        case ($urandom_range(0, 4))
          0: fn = 6'h20;
          1: fn = 6'h22;
          2: fn = 6'h24;
          3: fn = 6'h2a;
          default: fn = 6'h08;
        endcase
        return {6'h00, rs, rt, rd, 5'd0, fn};
      end
      2: return {6'h08, rs, rt, 16'h0005};
      3: return {6'h0c, rs, rt, 16'h00ff};
      4: return {6'h0d, rs, rt, 16'h0001};
      5: return {6'h0e, rs, rt, 16'h0f0f};
      6: return {6'h23, rs, rt, 16'h0010};
      7: return {6'h2b, rs, rt, 16'h0020};
      8: return {6'h04, rs, rt, 16'h0003};
      9: return {6'h05, rs, rt, 16'h0004};
      10: return {6'h02, 26'h0000040};
      11: return {6'h03, 26'h0000080};
      default: return {6'h0f, rs, rt, 16'h1234};
    endcase
  endfunction

  initial begin
    bus.in_valid = 0;
    bus.instA = 0;
    bus.instB = 0;
    bus.pcA = 0;
    bus.stall = 0;
    bus.flush = 0;
    cyc();
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_s0v", 32'(bus.slot0_valid), 32'd0);
    chk("rst_s0i", bus.slot0_inst, 32'd0);
    chk("rst_split", 32'(bus.split), 32'd0);

    // model pins on hand-decoded pairs
    chk("pin_add_add", 32'(pairable(32'h00221820, 32'h00853020)), 1);
    chk("pin_raw", 32'(pairable(32'h20080005, 32'h01084820)), 0);
    chk("pin_lw_sw", 32'(pairable(32'h8C220000, 32'hAC230004)), 0);
    chk("pin_beq", 32'(pairable(32'h10220003, 32'h00221820)), 0);
    chk("pin_r0", 32'(pairable(32'h00220020, 32'h00001820)), 1);

    cyc();
    rst = 0;
    put(32'h00221820, 32'h00853020, 32'h100);
    cyc();
    bus.in_valid = 0;
    @(negedge clk);
    chk("p1_s1v", 32'(bus.slot1_valid), 1);
    chk("p1_s1pc", bus.slot1_pc, 32'h104);
    chk("p1_split", 32'(bus.split), 0);

    cyc();
    put(32'h20080005, 32'h01084820, 32'h100);
    cyc();
    bus.in_valid = 0;
    @(negedge clk);
    chk("p2_s0i", bus.slot0_inst, 32'h20080005);
    chk("p2_s1v", 32'(bus.slot1_valid), 0);
    chk("p2_ready", 32'(bus.in_ready), 0);
    cyc();
    @(negedge clk);
    chk("p2_b_inst", bus.slot0_inst, 32'h01084820);
    chk("p2_b_pc", bus.slot0_pc, 32'h104);
    chk("p2_b_s1v", 32'(bus.slot1_valid), 0);

    // flush while holding B
    cyc();
    put(32'h8C220000, 32'hAC230004, 32'h200);
    cyc();
    bus.in_valid = 0;
    bus.flush = 1;
    cyc();
    bus.flush = 0;
    @(negedge clk);
    chk("fl_s0v", 32'(bus.slot0_valid), 0);
    chk("fl_ready", 32'(bus.in_ready), 1);
    cyc();
    @(negedge clk);
    chk("fl_nob", 32'(bus.slot0_valid), 0);

    // stall three cycles with a pair waiting
    put(32'h00221820, 32'h00853020, 32'h300);
    bus.stall = 1;
    repeat (3) begin
      cyc();
      @(negedge clk);
      chk("st_ready", 32'(bus.in_ready), 0);
    end
    cyc();
    bus.stall = 0;
    cyc();
    bus.in_valid = 0;
    @(negedge clk);
    chk("st_issue", bus.slot0_pc, 32'h300);

    // reset while holding B; wrapping PC
    cyc();
    put(32'h10220003, 32'h00221820, 32'hFFFFFFFC);
    cyc();
    bus.in_valid = 0;
    @(negedge clk);
    chk("wr_s0pc", bus.slot0_pc, 32'hFFFFFFFC);
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    chk("rh_s0v", 32'(bus.slot0_valid), 0);
    chk("rh_s0pc", bus.slot0_pc, 32'd0);
    cyc();
    @(negedge clk);
    chk("rh_lost", 32'(bus.slot0_valid), 0);

`ifdef ISSUE_STATS_EN
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    put(32'h00221820, 32'h00853020, 32'h400);
    repeat (5) cyc();
    put(32'h20080005, 32'h01084820, 32'h500);
    cyc();
    bus.in_valid = 0;
    cyc();
    @(negedge clk);
    chk("cnt_dual", bus.dual_cnt, 32'd5);
    chk("cnt_single", bus.single_cnt, 32'd2);
`endif

    for (int k = 0; k < 3000; k++) begin
      cyc();
      rst = ($urandom_range(0, 199) == 0);
      bus.stall = ($urandom_range(0, 99) < 15);
      bus.flush = ($urandom_range(0, 99) < 5);
      if (!(bus.in_valid && !acc_last)) begin
        bus.in_valid = ($urandom_range(0, 9) < 7);
        bus.instA = rnd_inst();
        bus.instB = rnd_inst();
        bus.pcA = ($urandom_range(0, 7) == 0) ?
          32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
      end
    end
    cyc();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/issue_pair_scheduler.md
# issue_pair_scheduler

Dual-issue scheduler for the superscalar MIPS core. It sits between the fetch pair buffer and the two decode/execute lanes. Each cycle it takes an aligned instruction pair (A at `pcA`, B at `pcA+4`) and decides whether both may issue together or must be split. A split issues A first and holds B for the next cycle. It enforces the core's structural limits (one memory port, one branch unit in lane 0) and intra-pair register hazards.

## Interface
Parameters:
- `XLEN`, 32: instruction and PC width.

Ports:
- `clk`  in  1  clock. One clock domain; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  fetch presents a valid pair.
- `in_ready`  out  1  scheduler accepts the pair this cycle.
- `instA`, `instB`  in  XLEN  the pair's instruction words.
- `pcA`  in  XLEN  PC of `instA`.
- `stall`  in  1  downstream backpressure; hold all outputs.
- `flush`  in  1  branch/jump redirect; discard everything in flight.
- `slot0_valid`, `slot1_valid`  out  1  lane issue valids.
- `slot0_inst`, `slot1_inst`  out  XLEN  issued instruction words.
- `slot0_pc`, `slot1_pc`  out  XLEN  issued PCs.
- `split`  out  1  registered: the last accepted pair was split.

## Operation
- Classification per instruction:
  - Memory class: opcode 0x23 (lw) or 0x2b (sw).
  - Control class: opcodes 0x04, 0x05, 0x02, 0x03, or R-type (opcode 0x00) with funct 0x08 (jr).
  - ALU class: everything else, including unknown opcodes.
- Destination register:
  - R-type (except jr): rd.
  - addi/andi/ori/xori/lw: rt.
  - jal: register 31.
  - All other instructions: none.
  - A destination of register 0 counts as none.
- Source registers:
  - R-type: rs and rt.
  - addi/andi/ori/xori/lw/jr: rs.
  - sw/beq/bne: rs and rt.
  - j/jal and unknown opcodes: none.
- Split conditions (any one true):
  - A and B are both memory class.
  - A is control class.
  - B is control class.
  - A has a destination and B reads it (RAW).
  - A and B have the same destination (WAW).
- FSM states: `S_IDLE` and `S_HOLD`.
- `S_IDLE`:
  - `in_ready = !stall && !flush`.
  - When a pair is accepted and it is pairable: issue A in lane 0 and B in lane 1.
  - When a pair is accepted and it is not pairable: issue A alone in lane 0, latch B and `pcA+4`, and go to `S_HOLD`.
  - When no pair is accepted: issue nothing (both valids 0).
- `S_HOLD`:
  - `in_ready = 0`.
  - When `!stall`: issue the held B alone in lane 0 and return to `S_IDLE`.
- Priority of simultaneous inputs: `rst` > `flush` > `stall`.
- `flush`:
  - Next cycle, both valids are 0 and the state is `S_IDLE`.
  - Any held B is dropped.
  - The pair on the inputs is not accepted.
- `stall`: all output registers and the FSM keep their values. No pair is accepted.
- PC arithmetic: `pcA+4` is computed modulo 2^XLEN (wraps at the top of the address space).

## Timing
- Outputs are registered. An accepted pair appears on the slots in the cycle after acceptance (latency 1).
- A split pair occupies two consecutive issue cycles; its B appears on `slot0` two cycles after acceptance when there is no stall.
- Handshake: a pair transfers when `in_valid && in_ready`. Fetch must keep the pair stable until it transfers.
- Reset values: state `S_IDLE`; all valids 0; all inst, pc and `split` outputs 0. `in_ready` is 0 during the reset cycle.
- Reset applied in `S_HOLD` drops the held instruction.

## Configuration
- `ISSUE_STATS_EN` defined:
  - Adds outputs `dual_cnt` and `single_cnt`, each 32 bits.
  - Each counter increments on every non-stalled issue cycle of its kind (two lanes valid vs. one lane valid).
  - Counters wrap at 2^32 and are cleared by `rst`. They are not cleared by `flush`.
- `ISSUE_STATS_EN` undefined: both ports and both counters are absent.

## Structure
- The shared package `superscalar_pkg` holds:
  - the opcode and funct constants;
  - the class enum `CLS_ALU`, `CLS_MEM`, `CLS_CTRL`;
  - the state enum `S_IDLE`, `S_HOLD`.
- Sub-module `issue_decode` (combinational):
  - Input: one instruction word.
  - Outputs: `cls`, `dst` (5 bits), `dst_v`, `src1`, `src1_v`, `src2`, `src2_v`.
  - Instantiated twice, once for A and once for B.
- The top level contains the hazard compare logic, the FSM, the hold register and the output registers.

## Test plan
- Pair 0x00221820 (add $3,$1,$2) and 0x00853020 (add $6,$4,$5), `pcA`=0x100 -> next cycle both slots valid; `slot1_pc`=0x104; `split`=0.
- Pair 0x20080005 (addi $8,$0,5) and 0x01084820 (add $9,$8,$8) -> cycle+1: slot0 = addi alone; `in_ready`=0. Cycle+2: slot0 = add with pc 0x104; `slot1_valid`=0.
- Pair 0x8C220000 (lw) and 0xAC230004 (sw) -> split. Pair 0x10220003 (beq) and 0x00221820 -> split. Pair add $0,... with a reader of $0 -> not split.
- Split pair, then `flush` asserted while in `S_HOLD` -> next cycle both valids 0, held B never issues, `in_ready`=1 again.
- `stall` held for 3 cycles while a pair is presented -> `in_ready`=0 and slot outputs unchanged for all 3 cycles; the pair issues 1 cycle after `stall` drops.
- `rst` asserted in `S_HOLD` -> next cycle all outputs 0 and the held B is lost. With `ISSUE_STATS_EN`, 5 dual-issue cycles followed by 2 single-issue cycles -> `dual_cnt`=5, `single_cnt`=2.
